// File: rtl/julia_pixel_engine.sv
// Iterative Julia-set pixel engine: z <= z^2 + c in signed fixed point, two cycles per iteration.
// Optional Mandelbrot start (z0 = 0, c = pixel) when JULIA_MANDEL_EN is defined.
module julia_pixel_engine #(
   parameter int          DATA_W   = 32,
   parameter int          FRAC_W   = 24,
   parameter int          ITER_W   = 16,
   parameter logic [15:0] IN_COLOR = 16'h001F
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_x0,
   input  logic signed [DATA_W-1:0] in_y0,
   input  logic signed [DATA_W-1:0] cr,
   input  logic signed [DATA_W-1:0] ci,
   input  logic [ITER_W-1:0]        max_iter,
   input  logic [1:0]               color_mode,
`ifdef JULIA_MANDEL_EN
   input  logic                     mandel_sel,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_escaped,
   output logic [ITER_W-1:0]        out_iter,
   output logic [15:0]              out_color
);

   localparam int             PW      = 2 * DATA_W;
   localparam int             MW      = PW + 1;
   localparam logic [MW-1:0]  ESC_LIM = MW'(4) << (2 * FRAC_W);

   typedef enum logic [1:0] {IDLE, MUL, JUDGE, DONE} state_t;

   state_t state_q, state_d;

   logic signed [DATA_W-1:0] x_p0, y_p0, cr_p0, ci_p0;
   logic [ITER_W-1:0]        max_iter_p0, n_q;
   logic [1:0]               mode_p0;
   logic signed [PW-1:0]     xx_p1, yy_p1, xy_p1;

   logic signed [DATA_W-1:0] x_ld, y_ld, cr_ld, ci_ld;
   logic signed [PW-1:0]     xs_w, ys_w;
   logic [MW-1:0]            mag_p1;
   logic signed [MW-1:0]     diff_p1, dbl_p1;
   logic                     escape_p1, limit_p1;

   // Rescale a wide product term back to Q format and add c, wrapping at DATA_W.
   function automatic logic signed [DATA_W-1:0] scale_add(input logic signed [MW-1:0] v,
                                                          input logic signed [DATA_W-1:0] c);
      logic signed [MW-1:0] s;
      s = v >>> FRAC_W;
      scale_add = $signed(s[DATA_W-1:0]) + c;
   endfunction

   function automatic logic [15:0] map_color(input logic [ITER_W-1:0] n, input logic [1:0] mode);
      logic [15:0] it;
      it = 16'(n);
      case (mode)
         2'd1:    map_color = it;
         2'd2:    map_color = (it << 10) | it;
         default: map_color = (it << 12) | (it << 8) | it;
      endcase
   endfunction

   always_comb begin
      x_ld  = in_x0;
      y_ld  = in_y0;
      cr_ld = cr;
      ci_ld = ci;
`ifdef JULIA_MANDEL_EN
      if (mandel_sel) begin
         x_ld  = '0;
         y_ld  = '0;
         cr_ld = in_x0;
         ci_ld = in_y0;
      end
`endif
   end

   assign xs_w = {{DATA_W{x_p0[DATA_W-1]}}, x_p0};
   assign ys_w = {{DATA_W{y_p0[DATA_W-1]}}, y_p0};

   // Judge stage: squares are non-negative, so the magnitude sum is unsigned.
   assign mag_p1    = {1'b0, xx_p1} + {1'b0, yy_p1};
   assign diff_p1   = $signed({xx_p1[PW-1], xx_p1}) - $signed({yy_p1[PW-1], yy_p1});
   assign dbl_p1    = $signed({xy_p1, 1'b0});
   assign escape_p1 = mag_p1 > ESC_LIM;
   assign limit_p1  = n_q == max_iter_p0;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = MUL;
         end
         MUL:   state_d = JUDGE;
         JUDGE: state_d = (escape_p1 || limit_p1) ? DONE : MUL;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         n_q         <= '0;
         out_escaped <= 1'b0;
         out_iter    <= '0;
         out_color   <= '0;
      end else begin
         case (state_q)
            IDLE:  if (in_valid) n_q <= '0;
            JUDGE: begin
               if (escape_p1) begin
                  out_escaped <= 1'b1;
                  out_iter    <= n_q;
                  out_color   <= map_color(n_q, mode_p0);
               end else if (limit_p1) begin
                  out_escaped <= 1'b0;
                  out_iter    <= max_iter_p0;
                  out_color   <= IN_COLOR;
               end else begin
                  n_q <= n_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers: load at accept, square in MUL, advance z in JUDGE.
   always_ff @(posedge clk) begin
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_p0        <= x_ld;
               y_p0        <= y_ld;
               cr_p0       <= cr_ld;
               ci_p0       <= ci_ld;
               max_iter_p0 <= max_iter;
               mode_p0     <= color_mode;
            end
         end
         MUL: begin
            xx_p1 <= xs_w * xs_w;
            yy_p1 <= ys_w * ys_w;
            xy_p1 <= xs_w * ys_w;
         end
         JUDGE: begin
            if (!escape_p1 && !limit_p1) begin
               x_p0 <= scale_add(diff_p1, cr_p0);
               y_p0 <= scale_add(dbl_p1, ci_p0);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_julia_pixel_engine.sv
// Directed bench for julia_pixel_engine (Q8.24, 16-bit iteration counter).
module tb_julia_pixel_engine;

   localparam logic signed [31:0] ONE   = 32'sh0100_0000;
   localparam logic signed [31:0] ONE5  = 32'sh0180_0000;
   localparam logic signed [31:0] TWO   = 32'sh0200_0000;
   localparam logic signed [31:0] THREE = 32'sh0300_0000;

   logic               clk, reset_n, in_valid, in_ready, out_valid, out_ready, out_escaped;
   logic signed [31:0] in_x0, in_y0, cr, ci;
   logic [15:0]        max_iter, out_iter, out_color;
   logic [1:0]         color_mode;
`ifdef JULIA_MANDEL_EN
   logic               mandel_sel;
`endif

   int vectors, miscompares;

   julia_pixel_engine dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x0(in_x0), .in_y0(in_y0), .cr(cr), .ci(ci),
      .max_iter(max_iter), .color_mode(color_mode),
`ifdef JULIA_MANDEL_EN
      .mandel_sel(mandel_sel),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_escaped(out_escaped),
      .out_iter(out_iter), .out_color(out_color)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one job, scramble inputs after accept, and measure cycles from the accept cycle to out_valid.
   task automatic run_job(input logic signed [31:0] x0, y0, c_r, c_i, input logic [15:0] mi,
                          input logic [1:0] md, output int lat, output logic esc,
                          output logic [15:0] it, output logic [15:0] col);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      in_valid = 1'b1; in_x0 = x0; in_y0 = y0; cr = c_r; ci = c_i;
      max_iter = mi; color_mode = md;
      @(posedge clk); #1;
      in_valid = 1'b0; in_x0 = $urandom; in_y0 = $urandom; cr = $urandom; ci = $urandom;
      max_iter = 16'hFFFF; color_mode = ~md;
      lat = 1;
      while (!out_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      esc = out_escaped; it = out_iter; col = out_color;
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (out_escaped !== 1'b0) begin miscompares++; $display("FAIL reset_escaped got %b want 0", out_escaped); end
      vectors++; if (out_iter !== 16'd0) begin miscompares++; $display("FAIL reset_iter got %0d want 0", out_iter); end
      vectors++; if (out_color !== 16'h0000) begin miscompares++; $display("FAIL reset_color got %h want 0000", out_color); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_immediate_escape();
      int lat; logic esc; logic [15:0] it, col;
      run_job(THREE, 0, 0, 0, 16'd10, 2'd0, lat, esc, it, col);
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL esc0_latency got %0d want 3", lat); end
      vectors++; if (esc !== 1'b1) begin miscompares++; $display("FAIL esc0_escaped got %b want 1", esc); end
      vectors++; if (it !== 16'd0) begin miscompares++; $display("FAIL esc0_iter got %0d want 0", it); end
      vectors++; if (col !== 16'h0000) begin miscompares++; $display("FAIL esc0_color got %h want 0000", col); end
      release_result();
   endtask

   task automatic test_one_iter_modes();
      int lat; logic esc; logic [15:0] it, col;
      run_job(ONE5, 0, 0, 0, 16'd10, 2'd0, lat, esc, it, col);
      vectors++; if (lat !== 5) begin miscompares++; $display("FAIL it1_m0_latency got %0d want 5", lat); end
      vectors++; if (esc !== 1'b1 || it !== 16'd1) begin miscompares++; $display("FAIL it1_m0_result got esc=%b iter=%0d want esc=1 iter=1", esc, it); end
      vectors++; if (col !== 16'h1101) begin miscompares++; $display("FAIL it1_m0_color got %h want 1101", col); end
      release_result();
      run_job(ONE5, 0, 0, 0, 16'd10, 2'd2, lat, esc, it, col);
      vectors++; if (lat !== 5) begin miscompares++; $display("FAIL it1_m2_latency got %0d want 5", lat); end
      vectors++; if (col !== 16'h0401) begin miscompares++; $display("FAIL it1_m2_color got %h want 0401", col); end
      release_result();
   endtask

   task automatic test_bounded();
      int lat; logic esc; logic [15:0] it, col;
      run_job(0, 0, 0, 0, 16'd10, 2'd0, lat, esc, it, col);
      vectors++; if (lat !== 23) begin miscompares++; $display("FAIL bounded_latency got %0d want 23", lat); end
      vectors++; if (esc !== 1'b0 || it !== 16'd10) begin miscompares++; $display("FAIL bounded_result got esc=%b iter=%0d want esc=0 iter=10", esc, it); end
      vectors++; if (col !== 16'h001F) begin miscompares++; $display("FAIL bounded_color got %h want 001f", col); end
      release_result();
   endtask

   task automatic test_max_iter_zero();
      int lat; logic esc; logic [15:0] it, col;
      run_job(ONE5, 0, 0, 0, 16'd0, 2'd1, lat, esc, it, col);
      vectors++; if (lat !== 3 || esc !== 1'b0 || it !== 16'd0 || col !== 16'h001F) begin
         miscompares++; $display("FAIL mi0_inside got lat=%0d esc=%b iter=%0d col=%h want 3 0 0 001f", lat, esc, it, col); end
      release_result();
      run_job(THREE, 0, 0, 0, 16'd0, 2'd1, lat, esc, it, col);
      vectors++; if (lat !== 3 || esc !== 1'b1 || it !== 16'd0 || col !== 16'h0000) begin
         miscompares++; $display("FAIL mi0_escape got lat=%0d esc=%b iter=%0d col=%h want 3 1 0 0000", lat, esc, it, col); end
      release_result();
   endtask

   // Exercise cr, ci and the 2xy term; |z|^2 == 4 exactly must not escape.
   task automatic test_c_terms();
      int lat; logic esc; logic [15:0] it, col;
      run_job(0, 0, ONE, 0, 16'd10, 2'd1, lat, esc, it, col);
      vectors++; if (lat !== 9 || esc !== 1'b1 || it !== 16'd3 || col !== 16'h0003) begin
         miscompares++; $display("FAIL cr_path got lat=%0d esc=%b iter=%0d col=%h want 9 1 3 0003", lat, esc, it, col); end
      release_result();
      run_job(0, 0, 0, TWO, 16'd10, 2'd2, lat, esc, it, col);
      vectors++; if (lat !== 7 || esc !== 1'b1 || it !== 16'd2 || col !== 16'h0802) begin
         miscompares++; $display("FAIL ci_path got lat=%0d esc=%b iter=%0d col=%h want 7 1 2 0802", lat, esc, it, col); end
      release_result();
      run_job(ONE, ONE, 0, 0, 16'd10, 2'd3, lat, esc, it, col);
      vectors++; if (lat !== 7 || esc !== 1'b1 || it !== 16'd2 || col !== 16'h2202) begin
         miscompares++; $display("FAIL xy_path got lat=%0d esc=%b iter=%0d col=%h want 7 1 2 2202", lat, esc, it, col); end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat; logic esc; logic [15:0] it, col;
      run_job(ONE5, 0, 0, 0, 16'd10, 2'd0, lat, esc, it, col);
      vectors++; if (lat !== 5) begin miscompares++; $display("FAIL bp_latency got %0d want 5", lat); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_hold_handshake cyc %0d got valid=%b ready=%b want 1 0", k, out_valid, in_ready); end
         vectors++; if (out_escaped !== esc || out_iter !== it || out_color !== col) begin
            miscompares++; $display("FAIL bp_hold_data cyc %0d got %b %0d %h want %b %0d %h", k, out_escaped, out_iter, out_color, esc, it, col); end
      end
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL bp_release got ready=%b valid=%b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_reset_mid_job();
      int lat; logic esc; logic [15:0] it, col; int seen;
      @(negedge clk);
      in_valid = 1'b1; in_x0 = 0; in_y0 = 0; cr = 0; ci = 0; max_iter = 16'd100; color_mode = 2'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++; $display("FAIL abort_state got valid=%b ready=%b want 0 1", out_valid, in_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
      run_job(THREE, 0, 0, 0, 16'd10, 2'd0, lat, esc, it, col);
      vectors++; if (lat !== 3 || esc !== 1'b1 || it !== 16'd0) begin
         miscompares++; $display("FAIL abort_next_job got lat=%0d esc=%b iter=%0d want 3 1 0", lat, esc, it); end
      release_result();
   endtask

`ifdef JULIA_MANDEL_EN
   task automatic test_mandel();
      int lat; logic esc; logic [15:0] it, col;
      mandel_sel = 1'b1;
      run_job(-ONE, 0, THREE, THREE, 16'd50, 2'd0, lat, esc, it, col);
      mandel_sel = 1'b0;
      vectors++; if (lat !== 103 || esc !== 1'b0 || it !== 16'd50 || col !== 16'h001F) begin
         miscompares++; $display("FAIL mandel got lat=%0d esc=%b iter=%0d col=%h want 103 0 50 001f", lat, esc, it, col); end
      release_result();
   endtask
`endif

   initial begin
      vectors = 0; miscompares = 0;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_x0 = 0; in_y0 = 0; cr = 0; ci = 0; max_iter = 0; color_mode = 0;
`ifdef JULIA_MANDEL_EN
      mandel_sel = 1'b0;
`endif
      test_reset();
      test_immediate_escape();
      test_one_iter_modes();
      test_bounded();
      test_max_iter_zero();
      test_c_terms();
      test_backpressure();
      test_reset_mid_job();
`ifdef JULIA_MANDEL_EN
      test_mandel();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
